// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Generates sequential fetch addresses,
// runs a single-outstanding req/ack transaction with instruction memory and
// buffers returned words in a 2-entry queue that feeds the IF/ID register.
//
// Memory handshake: mem_req acts as "valid" and mem_ack as "ready". Once
// mem_req rises, it and mem_addr hold steady until a rising CLK edge sees
// mem_req=1 and mem_ack=1 (one transfer). mem_ack may rise in the same
// cycle as mem_req. mem_ack while mem_req=0 carries no meaning and is ignored.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] OPC,
  output logic [15:0] OIR,
  output logic        FetchWrite
);

  // S_DROP: a request issued before a redirect is still outstanding. Its
  // data belongs to the abandoned path and is thrown away on arrival.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [15:0]       nxt;
  logic [15:0]       nxt_nx;
  logic [15:0]       req_addr;
  logic [15:0]       req_addr_nx;
  logic [1:0]        occ;
  logic [1:0]        occ_nx;
  logic [1:0]        occ_n;
  logic [1:0]        wr_sel;
  logic [1:0][15:0]  pc_q;
  logic [1:0][15:0]  ir_q;
  logic              transfer;
  logic              push;
  logic              pop;

  assign mem_req    = (state != S_IDLE);
  assign mem_addr   = req_addr;
  assign transfer   = mem_req & mem_ack;
  assign FetchWrite = (occ != 2'd0) & ~stall & ~redirect;
  assign pop        = FetchWrite;
  // Only data fetched on the current path is kept; a redirect kills it.
  assign push       = (state == S_REQ) & transfer & ~redirect;
  assign occ_n      = occ + {1'b0, push} - {1'b0, pop};
  // Slot the new word lands in, after the head (if popped) has shifted out.
  assign wr_sel     = occ - {1'b0, pop};
  assign OPC        = (occ != 2'd0) ? pc_q[0] : 16'h0000;
  assign OIR        = (occ != 2'd0) ? ir_q[0] : 16'h0000;

  // State, address and occupancy registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      nxt      <= RESET_PC;
      req_addr <= RESET_PC;
      occ      <= 2'd0;
    end else begin
      state    <= state_nx;
      nxt      <= nxt_nx;
      req_addr <= req_addr_nx;
      occ      <= occ_nx;
    end
  end

  // Next-state logic. A redirect flushes the queue from any state; requests
  // are only issued when the queue is guaranteed room for the reply.
  always_comb begin
    state_nx    = state;
    nxt_nx      = nxt;
    req_addr_nx = req_addr;
    occ_nx      = occ_n;
    if (redirect) begin
      occ_nx = 2'd0;
      nxt_nx = redirect_pc;
      if ((state == S_IDLE) || transfer) begin
        req_addr_nx = redirect_pc;
        state_nx    = S_REQ;
      end else begin
        state_nx = S_DROP;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (occ_n <= 2'd1) begin
            req_addr_nx = nxt;
            state_nx    = S_REQ;
          end
        end
        S_REQ: begin
          if (transfer) begin
            nxt_nx = req_addr + PC_STEP;
            if (occ_n <= 2'd1) begin
              req_addr_nx = req_addr + PC_STEP;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (transfer) begin
            req_addr_nx = nxt;
            state_nx    = S_REQ;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Two-entry queue: slot 0 is the head; a pop shifts slot 1 down.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (pop) begin
        pc_q[0] <= pc_q[1];
        ir_q[0] <= ir_q[1];
      end
      if (push) begin
        if (wr_sel == 2'd0) begin
          pc_q[0] <= req_addr;
          ir_q[0] <= mem_rdata;
        end else begin
          pc_q[1] <= req_addr;
          ir_q[1] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with a latency-programmable memory
// responder and a queue-based scoreboard of expected {pc, ir} entries.
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] OPC;
  logic [15:0] OIR;
  logic        FetchWrite;

  always #5 clk = ~clk;

  fetch_unit dut (
    .CLK(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .OPC(OPC),
    .OIR(OIR),
    .FetchWrite(FetchWrite)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  bit          mon_en = 1'b0;
  bit          drop_pending = 1'b0;
  logic [15:0] exp_addr = 16'h0000;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] ir_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Per-cycle scoreboard: head/FetchWrite against the model, pop on write,
  // push on a kept transfer, flush on redirect.
  task automatic monitor_cycle();
    logic        exp_fw;
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;
    exp_fw = (exp_q.size() != 0) && !stall && !redirect;
    checks++;
    if (FetchWrite !== exp_fw) begin
      failures++;
      $display("FAIL sb_fetchwrite t=%0t got=%b exp=%b", $time, FetchWrite, exp_fw);
    end
    exp_pc = 16'h0000;
    exp_ir = 16'h0000;
    if (exp_q.size() != 0) begin
      exp_pc = exp_q[0][31:16];
      exp_ir = exp_q[0][15:0];
    end
    checks++;
    if (OPC !== exp_pc || OIR !== exp_ir) begin
      failures++;
      $display("FAIL sb_head t=%0t got=%h/%h exp=%h/%h", $time, OPC, OIR, exp_pc, exp_ir);
    end
    if (exp_fw) void'(exp_q.pop_front());
    if (redirect) begin
      drop_pending = (mem_req === 1'b1) && (mem_ack !== 1'b1);
      exp_q.delete();
      exp_addr = redirect_pc;
    end else if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      if (drop_pending) begin
        drop_pending = 1'b0;
      end else begin
        checks++;
        if (mem_addr !== exp_addr) begin
          failures++;
          $display("FAIL sb_mem_addr t=%0t got=%h exp=%h", $time, mem_addr, exp_addr);
        end
        exp_q.push_back({exp_addr, ir_of(exp_addr)});
        exp_addr = exp_addr + 16'd2;
      end
    end
  endtask

  // Memory responder (acks after mem_lat waiting cycles), then scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (mem_req === 1'b1 && !reset) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = ir_of(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom_range(0, 65535));
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    #1;
    if (mon_en) monitor_cycle();
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b1;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (OPC !== 16'h0000) begin failures++; $display("FAIL reset_opc got=%h exp=0000", OPC); end
    checks++; if (OIR !== 16'h0000) begin failures++; $display("FAIL reset_oir got=%h exp=0000", OIR); end
    checks++; if (FetchWrite !== 1'b0) begin failures++; $display("FAIL reset_fw got=%b exp=0", FetchWrite); end
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Called right at reset release: cycle c is the c-th negedge afterwards.
  task automatic test_stream();
    mem_lat = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      #3;
      if (c == 1) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL stream_first_req got=%b/%h exp=1/0000", mem_req, mem_addr); end
        checks++; if (FetchWrite !== 1'b0) begin failures++; $display("FAIL stream_c1_fw got=%b exp=0", FetchWrite); end
      end else begin
        checks++; if (FetchWrite !== 1'b1) begin failures++; $display("FAIL stream_fw c=%0d got=%b exp=1", c, FetchWrite); end
        checks++; if (OPC !== 16'((c - 2) * 2)) begin failures++; $display("FAIL stream_opc c=%0d got=%h exp=%h", c, OPC, 16'((c - 2) * 2)); end
        checks++; if (mem_addr !== 16'((c - 1) * 2)) begin failures++; $display("FAIL stream_addr c=%0d got=%h exp=%h", c, mem_addr, 16'((c - 1) * 2)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] held_pc;
    logic [15:0] next_req;
    @(negedge clk);
    stall = 1'b1;
    #3;
    checks++; if (mem_req !== 1'b1 || mem_ack !== 1'b1) begin failures++; $display("FAIL stall_s0_xfer got=%b/%b exp=1/1", mem_req, mem_ack); end
    held_pc = exp_q[0][31:16];
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #3;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_req_low i=%0d got=%b exp=0", i, mem_req); end
      checks++; if (FetchWrite !== 1'b0) begin failures++; $display("FAIL stall_fw i=%0d got=%b exp=0", i, FetchWrite); end
      checks++; if (OPC !== held_pc) begin failures++; $display("FAIL stall_frozen i=%0d got=%h exp=%h", i, OPC, held_pc); end
    end
    @(negedge clk);
    stall = 1'b0;
    #3;
    checks++; if (FetchWrite !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL stall_release got=%b/%b exp=1/0", FetchWrite, mem_req); end
    next_req = exp_addr;
    @(negedge clk);
    #3;
    checks++; if (mem_req !== 1'b1 || mem_addr !== next_req) begin failures++; $display("FAIL stall_rereq got=%b/%h exp=1/%h", mem_req, mem_addr, next_req); end
  endtask

  task automatic test_drop();
    bit          found;
    logic [15:0] stale;
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #3;
      if (mem_req === 1'b1 && mem_ack === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL drop_wait_req got=timeout exp=pending_request"); end
    stale = exp_addr;
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    #3;
    checks++; if (FetchWrite !== 1'b0) begin failures++; $display("FAIL drop_redirect_fw got=%b exp=0", FetchWrite); end
    checks++; if (mem_addr !== stale) begin failures++; $display("FAIL drop_hold0 got=%h exp=%h", mem_addr, stale); end
    @(negedge clk);
    redirect = 1'b0;
    #3;
    checks++; if (mem_req !== 1'b1 || mem_addr !== stale || mem_ack !== 1'b0) begin failures++; $display("FAIL drop_hold1 got=%b/%h/%b exp=1/%h/0", mem_req, mem_addr, mem_ack, stale); end
    @(negedge clk);
    #3;
    checks++; if (mem_ack !== 1'b1 || mem_addr !== stale) begin failures++; $display("FAIL drop_stale_ack got=%b/%h exp=1/%h", mem_ack, mem_addr, stale); end
    @(negedge clk);
    #3;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin failures++; $display("FAIL drop_new_req got=%b/%h exp=1/0100", mem_req, mem_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #3;
      if (FetchWrite === 1'b1) found = 1'b1;
    end
    checks++; if (!found || OPC !== 16'h0100 || OIR !== ir_of(16'h0100)) begin failures++; $display("FAIL drop_target got=%b/%h/%h exp=1/0100/%h", found, OPC, OIR, ir_of(16'h0100)); end
    mem_lat = 0;
  endtask

  task automatic test_redirect_ack();
    repeat (3) @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 16'h0040;
    #3;
    checks++; if (FetchWrite !== 1'b0 || mem_ack !== 1'b1) begin failures++; $display("FAIL rdack_cycle got=%b/%b exp=0/1", FetchWrite, mem_ack); end
    @(negedge clk);
    redirect = 1'b0;
    stall    = 1'b0;
    #3;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL rdack_next_addr got=%b/%h exp=1/0040", mem_req, mem_addr); end
    checks++; if (FetchWrite !== 1'b0 || OPC !== 16'h0000) begin failures++; $display("FAIL rdack_flushed got=%b/%h exp=0/0000", FetchWrite, OPC); end
    @(negedge clk);
    #3;
    checks++; if (FetchWrite !== 1'b1 || OPC !== 16'h0040 || OIR !== ir_of(16'h0040)) begin failures++; $display("FAIL rdack_target got=%b/%h/%h exp=1/0040/%h", FetchWrite, OPC, OIR, ir_of(16'h0040)); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    #3;
    @(negedge clk);
    redirect = 1'b0;
    #3;
    checks++; if (mem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffe", mem_addr); end
    @(negedge clk);
    #3;
    checks++; if (mem_addr !== 16'h0000 || OPC !== 16'hFFFE) begin failures++; $display("FAIL wrap_step1 got=%h/%h exp=0000/fffe", mem_addr, OPC); end
    @(negedge clk);
    #3;
    checks++; if (mem_addr !== 16'h0002 || OPC !== 16'h0000) begin failures++; $display("FAIL wrap_step2 got=%h/%h exp=0002/0000", mem_addr, OPC); end
    @(negedge clk);
    #3;
    checks++; if (OPC !== 16'h0002 || FetchWrite !== 1'b1) begin failures++; $display("FAIL wrap_step3 got=%h/%b exp=0002/1", OPC, FetchWrite); end
  endtask

  task automatic test_reset_mid();
    bit found;
    @(negedge clk);
    stall   = 1'b1;
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i != 0) @(negedge clk);
      #3;
      if (mem_req === 1'b1 && mem_ack === 1'b0 && exp_q.size() == 1) found = 1'b1;
      else #0;
      if (!found) #1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_setup got=timeout exp=req_outstanding_occ1"); end
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin failures++; $display("FAIL rmid_req got=%b/%h exp=0/0000", mem_req, mem_addr); end
    checks++; if (OPC !== 16'h0000 || OIR !== 16'h0000) begin failures++; $display("FAIL rmid_head got=%h/%h exp=0000/0000", OPC, OIR); end
    checks++; if (FetchWrite !== 1'b0) begin failures++; $display("FAIL rmid_fw got=%b exp=0", FetchWrite); end
    @(negedge clk);
    reset        = 1'b0;
    stall        = 1'b0;
    mem_lat      = 0;
    exp_q.delete();
    exp_addr     = 16'h0000;
    drop_pending = 1'b0;
    mon_en       = 1'b1;
    @(negedge clk);
    #3;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL rmid_restart got=%b/%h exp=1/0000", mem_req, mem_addr); end
    @(negedge clk);
    #3;
    checks++; if (FetchWrite !== 1'b1 || OPC !== 16'h0000 || OIR !== ir_of(16'h0000)) begin failures++; $display("FAIL rmid_first got=%b/%h/%h exp=1/0000/%h", FetchWrite, OPC, OIR, ir_of(16'h0000)); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
